alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The parameter SHALL be CHUNK, default 8: operand bits processed per clock; legal values 1, 2, 4, 8, 16, 32, 64; CHUNK does not affect results, only latency.
REQ-002 The port clk SHALL be input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be input, 1 bit: reset, synchronous, active-high.
REQ-004 The port start SHALL be input, 1 bit: request a new operation; sampled only in IDLE or DONE.
REQ-005 The port ifun SHALL be input, 4 bits: Y86 OPq function code; 0 = add, 1 = sub, 2 = and, 3 = xor; 4-15 are invalid.
REQ-006 The port alua SHALL be input, 64 bits: operand valA.
REQ-007 The port alub SHALL be input, 64 bits: operand valB.
REQ-008 The port set_cc SHALL be input, 1 bit: update condition codes when this operation completes.
REQ-009 The port busy SHALL be output, 1 bit: high while in RUN.
REQ-010 The port done SHALL be output, 1 bit: one-cycle completion pulse.
REQ-011 The port vale SHALL be output, 64 bits: result valE, held from done until the next completion or reset.
REQ-012 The ports zf, sf and of SHALL each be output, 1 bit: registered condition codes.
REQ-013 The port err SHALL be output, 1 bit: invalid-ifun flag, pulses together with done.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
- IDLE→RUN on start.
- RUN→DONE after 64/CHUNK chunk cycles.
- DONE→RUN if start, else DONE→IDLE.
REQ-015 On accepting start, the block SHALL latch alua, alub, ifun and set_cc; later changes to these inputs SHALL NOT affect the operation in flight.
REQ-016 While in RUN, start SHALL be ignored: no queueing, no restart.
REQ-017 Each RUN cycle SHALL process bits [i*CHUNK +: CHUNK], low chunk first, and carry a 1-bit carry/borrow between chunks.
- add: valB + valA.
- sub: valB - valA, computed as valB + ~valA + 1, with carry-in 1 on chunk 0.
- and / xor: bitwise.
REQ-018 done SHALL be high exactly 64/CHUNK+1 cycles after the cycle in which start was sampled (9 cycles for CHUNK=8).
REQ-019 done SHALL be high for exactly one cycle per operation.
REQ-020 vale SHALL update on the same edge that raises done.
REQ-021 busy SHALL be high for exactly 64/CHUNK cycles per operation.
REQ-022 Condition codes SHALL update only on the edge that raises done, and only if the latched set_cc = 1 and ifun is valid; otherwise they hold.
- zf = (vale == 0).
- sf = vale[63].
- of, add: a[63]==b[63] && r[63]!=a[63].
- of, sub: a[63]!=b[63] && r[63]!=b[63].
- of, and/xor: 0.
REQ-023 For an invalid ifun, the operation SHALL still take full latency; at done: vale = 0, err = 1, CC unchanged.
REQ-024 err SHALL be 0 whenever done is 0.
REQ-025 Start asserted during the DONE cycle SHALL be accepted; done then reoccurs after full latency with no gap cycle lost.
REQ-026 Arithmetic SHALL wrap modulo 2^64; the final carry-out SHALL be discarded.

Reset
REQ-027 When rst is high at a clock edge, the block SHALL enter IDLE with busy = 0, done = 0, err = 0, vale = 0, zf = 1, sf = 0, of = 0.
REQ-028 Reset SHALL take priority over start and over an operation in flight; an aborted operation SHALL produce no done and no CC update.
REQ-029 The first start SHALL be accepted in the cycle immediately after rst deasserts.

Verification
REQ-030 Bench SHALL cover xor: ifun=3, alua=0xFFFF0000FFFF0000, alub=0x0F0F0F0F0F0F0F0F, set_cc=1 -> done 9 cycles later; vale=0xF0F00F0FF0F00F0F; zf=0, sf=1, of=0.
REQ-031 Bench SHALL cover add overflow: ifun=0, alua=0x7FFFFFFFFFFFFFFF, alub=1, set_cc=1 -> vale=0x8000000000000000; zf=0, sf=1, of=1.
REQ-032 Bench SHALL cover sub: ifun=1, alua=alub=0x123, set_cc=1 -> vale=0, zf=1; then ifun=1, alua=1, alub=0, set_cc=0 -> vale=0xFFFFFFFFFFFFFFFF with CC still zf=1, sf=0.
REQ-033 Bench SHALL cover handshake: start pulsed during RUN -> ignored, a single done; start held high in the DONE cycle -> second done exactly 9 cycles later.
REQ-034 Bench SHALL cover reset mid-operation: rst on the 4th RUN cycle -> next cycle busy=0, vale=0, zf=1; no done for the aborted operation.
REQ-035 Bench SHALL cover invalid ifun: ifun=5, set_cc=1 -> done with err=1, vale=0, CC unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential 64-bit Y86 OPq ALU: processes CHUNK operand bits per clock,
// low chunk first, with a 1-bit carry/borrow between chunks.
module alu_seq #(
  parameter int unsigned CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  ifun,
  input  logic [63:0] alua,
  input  logic [63:0] alub,
  input  logic        set_cc,
  output logic        busy,
  output logic        done,
  output logic [63:0] vale,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        err
);

  localparam int unsigned NumChunks = 64 / CHUNK;
  localparam logic [6:0]  LastCnt   = 7'(NumChunks - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [63:0] a_q, b_q, res_q, vale_q;
  logic [3:0]  ifun_q;
  logic        set_cc_q, carry_q, a_msb_q, b_msb_q;
  logic [6:0]  cnt_q;
  logic        done_q, err_q, zf_q, sf_q, of_q;

  logic             accept, last, finish, op_valid, is_sub;
  logic [CHUNK-1:0] a_c, b_c, op_c;
  logic [CHUNK:0]   sum_w;
  logic [63:0]      res_next, final_r;
  logic             of_next;

  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
  assign last     = (cnt_q == LastCnt);
  assign finish   = (state_q == StRun) && last;
  assign op_valid = (ifun_q < 4'd4);
  assign is_sub   = (ifun_q == 4'd1);

  // One chunk of the datapath plus assembly of the shifted-in result word.
  always_comb begin
    a_c   = a_q[CHUNK-1:0];
    b_c   = b_q[CHUNK-1:0];
    // Subtraction is valB + ~valA + 1; the +1 enters as the initial carry.
    sum_w = {1'b0, b_c} + {1'b0, (is_sub ? ~a_c : a_c)} + {{CHUNK{1'b0}}, carry_q};
    case (ifun_q)
      4'd0, 4'd1: op_c = sum_w[CHUNK-1:0];
      4'd2:       op_c = a_c & b_c;
      4'd3:       op_c = a_c ^ b_c;
      default:    op_c = '0;
    endcase
    // Result fills from the top so it is aligned after the last chunk.
    res_next = (res_q >> CHUNK) | (64'(op_c) << (64 - CHUNK));
    final_r  = op_valid ? res_next : 64'd0;
    case (ifun_q)
      4'd0:    of_next = (a_msb_q == b_msb_q) && (res_next[63] != a_msb_q);
      4'd1:    of_next = (a_msb_q != b_msb_q) && (res_next[63] != b_msb_q);
      default: of_next = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == StRun);
  end

  // Operand latch, chunk iteration, result and condition-code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      vale_q   <= '0;
      ifun_q   <= '0;
      set_cc_q <= 1'b0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      zf_q     <= 1'b1;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      done_q <= finish;
      err_q  <= finish && !op_valid;
      if (accept) begin
        a_q      <= alua;
        b_q      <= alub;
        ifun_q   <= ifun;
        set_cc_q <= set_cc;
        carry_q  <= (ifun == 4'd1);
        a_msb_q  <= alua[63];
        b_msb_q  <= alub[63];
        cnt_q    <= '0;
        res_q    <= '0;
      end else if (state_q == StRun) begin
        a_q     <= a_q >> CHUNK;
        b_q     <= b_q >> CHUNK;
        res_q   <= res_next;
        carry_q <= sum_w[CHUNK];
        cnt_q   <= cnt_q + 7'd1;
        if (last) begin
          vale_q <= final_r;
          if (set_cc_q && op_valid) begin
            zf_q <= (res_next == 64'd0);
            sf_q <= res_next[63];
            of_q <= of_next;
          end
        end
      end
    end
  end

  assign done = done_q;
  assign err  = err_q;
  assign vale = vale_q;
  assign zf   = zf_q;
  assign sf   = sf_q;
  assign of   = of_q;

endmodule
